// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the MIPS multicycle control unit: FSM states,
// opcode/funct encodings and ALU operation codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_IMMEX  = 4'd8,
    S_IMMWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_NOR = 3'b110;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Shared instruction/data memory handshake between control unit and memory.
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic iord;
  logic memwrite;
  logic mem_ready;

  modport master (output mem_req, iord, memwrite, input mem_ready);
  modport slave  (input mem_req, iord, memwrite, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode: R-type funct code with legality flag,
// and I-type opcode code.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_r,
  output logic       r_legal,
  output logic [2:0] alu_i
);

  always_comb begin
    alu_r   = ALU_ADD;
    r_legal = 1'b1;
    case (funct)
      FN_ADD:  alu_r = ALU_ADD;
      FN_SUB:  alu_r = ALU_SUB;
      FN_AND:  alu_r = ALU_AND;
      FN_OR:   alu_r = ALU_OR;
      FN_NOR:  alu_r = ALU_NOR;
      FN_SLT:  alu_r = ALU_SLT;
      default: r_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_i = ALU_ADD;
    case (opcode)
      OP_ANDI: alu_i = ALU_AND;
      OP_ORI:  alu_i = ALU_OR;
      OP_SLTI: alu_i = ALU_SLT;
      default: alu_i = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with retired-instruction counter.
// Define MC_TRAP_EN to route illegal instructions through a one-cycle trap.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ACTRL_W = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  mips_multicycle_ctrl_if.master mem,
  output logic                irwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [ACTRL_W-1:0]  aluctrl,
  output logic [1:0]          pcsrc,
  output logic                pcen,
  output logic                illegal,
  output logic [CNT_W-1:0]    instret
);

  state_t     state, next;
  logic       retire;
  logic       mem_req, iord, memwrite;
  logic [2:0] alu_op, alu_r, alu_i;
  logic       r_legal;
  state_t     bad_target;

  mips_alu_decoder u_alu_decoder (
    .opcode  (opcode),
    .funct   (funct),
    .alu_r   (alu_r),
    .r_legal (r_legal),
    .alu_i   (alu_i)
  );

`ifdef MC_TRAP_EN
  assign bad_target = S_TRAP;
`else
  assign bad_target = S_FETCH;
`endif

  always_comb begin
    next     = state;
    retire   = 1'b0;
    mem_req  = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    alu_op   = ALU_ADD;
    pcsrc    = 2'b00;
    pcen     = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem.mem_ready;
        pcen    = mem.mem_ready;
        if (mem.mem_ready) next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                      next = S_MEMADR;
          OP_RTYPE:                          next = r_legal ? S_RTYPE : bad_target;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next = S_IMMEX;
          OP_BEQ, OP_BNE:                    next = S_BRANCH;
          OP_J:                              next = S_JUMP;
          default:                           next = bad_target;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem.mem_ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        retire   = mem.mem_ready;
      end
      S_RTYPE: begin
        alusrca = 1'b1;
        alu_op  = alu_r;
        next    = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alu_op  = alu_i;
        next    = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        alu_op  = ALU_SUB;
        pcsrc   = 2'b01;
        pcen    = (opcode == OP_BNE) ? !zero : zero;
        retire  = 1'b1;
      end
      S_JUMP: begin
        pcsrc  = 2'b10;
        pcen   = 1'b1;
        retire = 1'b1;
      end
      S_TRAP: begin
`ifdef MC_TRAP_EN
        illegal = 1'b1;
        pcsrc   = 2'b11;
        pcen    = 1'b1;
`endif
        next = S_FETCH;
      end
      default: next = S_FETCH;
    endcase
    // Every retiring state returns to fetch on its exit edge.
    if (retire) next = S_FETCH;
  end

  always_comb begin
    aluctrl      = '0;
    aluctrl[2:0] = alu_op;
  end

  assign mem.mem_req  = mem_req;
  assign mem.iord     = iord;
  assign mem.memwrite = memwrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= next;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomised bench for mips_multicycle_ctrl against a per-instruction
// reference model of the expected control word sequence.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluctrl;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal;
  } ctl_t;

  typedef struct {
    ctl_t c;
    logic rdy;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] aluctrl;
  logic [3:0] instret;
  ctl_t       dut_c;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] cnt     = '0;
  step_t      q[$];

  mips_multicycle_ctrl_if mem_if ();

  mips_multicycle_ctrl #(.ACTRL_W(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .funct    (funct),
    .zero     (zero),
    .mem      (mem_if),
    .irwrite  (irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .aluctrl  (aluctrl),
    .pcsrc    (pcsrc),
    .pcen     (pcen),
    .illegal  (illegal),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  always_comb dut_c = {mem_if.mem_req, mem_if.iord, mem_if.memwrite, irwrite, regdst,
                       memtoreg, regwrite, alusrca, alusrcb, aluctrl, pcsrc, pcen, illegal};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ALU code an R-type funct should produce; legal=0 for unsupported funct values.
  function automatic logic [3:0] funct_alu(input logic [5:0] fn, output bit legal);
    legal = 1;
    case (fn)
      6'b100000: return 4'b0000;
      6'b100010: return 4'b0001;
      6'b100100: return 4'b0010;
      6'b100101: return 4'b0011;
      6'b100111: return 4'b0110;
      6'b101010: return 4'b0101;
      default: begin legal = 0; return 4'b0000; end
    endcase
  endfunction

  function automatic bit known_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001100,
                      6'b001101, 6'b001010, 6'b000100, 6'b000101, 6'b000010};
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input ctl_t c, input logic rdy);
    step_t s;
    s.c = c;
    s.rdy = rdy;
    q.push_back(s);
  endtask

  task automatic push_illegal();
`ifdef MC_TRAP_EN
    ctl_t c;
    c = '0; c.illegal = 1; c.pcsrc = 2'b11; c.pcen = 1;
    push(c, rnd_bit());
`endif
  endtask

  // Expected cycle-by-cycle control words for one instruction.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw, output bit ret);
    ctl_t c;
    bit   legal;
    logic [3:0] code;
    ret = 0;
    c = '0; c.mem_req = 1; c.alusrcb = 2'b01;
    for (int i = 0; i < fw; i++) push(c, 1'b0);
    c.irwrite = 1; c.pcen = 1;
    push(c, 1'b1);
    c = '0; c.alusrcb = 2'b11;
    push(c, rnd_bit());
    case (op)
      6'b100011, 6'b101011: begin
        c = '0; c.alusrca = 1; c.alusrcb = 2'b10;
        push(c, rnd_bit());
        c = '0; c.mem_req = 1; c.iord = 1; c.memwrite = (op == 6'b101011);
        for (int i = 0; i < mw; i++) push(c, 1'b0);
        push(c, 1'b1);
        if (op == 6'b100011) begin
          c = '0; c.regwrite = 1; c.memtoreg = 1;
          push(c, rnd_bit());
        end
        ret = 1;
      end
      6'b000000: begin
        code = funct_alu(fn, legal);
        if (legal) begin
          c = '0; c.alusrca = 1; c.aluctrl = code;
          push(c, rnd_bit());
          c = '0; c.regwrite = 1; c.regdst = 1;
          push(c, rnd_bit());
          ret = 1;
        end else push_illegal();
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        c = '0; c.alusrca = 1; c.alusrcb = 2'b10;
        c.aluctrl = (op == 6'b001100) ? 4'b0010 : (op == 6'b001101) ? 4'b0011 :
                    (op == 6'b001010) ? 4'b0101 : 4'b0000;
        push(c, rnd_bit());
        c = '0; c.regwrite = 1;
        push(c, rnd_bit());
        ret = 1;
      end
      6'b000100, 6'b000101: begin
        c = '0; c.alusrca = 1; c.aluctrl = 4'b0001; c.pcsrc = 2'b01;
        c.pcen = (op == 6'b000101) ? !z : z;
        push(c, rnd_bit());
        ret = 1;
      end
      6'b000010: begin
        c = '0; c.pcsrc = 2'b10; c.pcen = 1;
        push(c, rnd_bit());
        ret = 1;
      end
      default: push_illegal();
    endcase
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    bit ret;
    q.delete();
    build(op, fn, z, fw, mw, ret);
    foreach (q[i]) begin
      @(negedge clk);
      if (i == 0) begin
        opcode = op;
        funct  = fn;
        zero   = z;
      end
      mem_if.mem_ready = q[i].rdy;
      #1;
      if (i == 0) check($sformatf("instret op=%b", op), 64'(instret), 64'(cnt));
      check($sformatf("ctl op=%b fn=%b cyc=%0d", op, fn, i), 64'(dut_c), 64'(q[i].c));
    end
    if (ret) cnt++;
  endtask

  task automatic run_random();
    logic [5:0] op, fn;
    bit legal;
    int k;
    logic [3:0] tmp;
    k  = int'($urandom_range(0, 9));
    fn = 6'($urandom);
    case (k)
      0: op = 6'b100011;
      1: op = 6'b101011;
      2: begin
        op = 6'b000000;
        fn = 6'($urandom_range(0, 5));
        fn = (fn == 0) ? 6'b100000 : (fn == 1) ? 6'b100010 : (fn == 2) ? 6'b100100 :
             (fn == 3) ? 6'b100101 : (fn == 4) ? 6'b100111 : 6'b101010;
      end
      3: begin
        op = 6'b000000;
        do begin
          fn = 6'($urandom);
          tmp = funct_alu(fn, legal);
        end while (legal);
      end
      4: op = 6'b001000;
      5: op = (rnd_bit()) ? 6'b001100 : ((rnd_bit()) ? 6'b001101 : 6'b001010);
      6: op = 6'b000100;
      7: op = 6'b000101;
      8: op = 6'b000010;
      default: begin
        do op = 6'($urandom); while (known_op(op));
      end
    endcase
    run_instr(op, fn, rnd_bit(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
  endtask

  initial begin
    ctl_t c;
    rst_n = 1'b0;
    opcode = '0;
    funct = '0;
    zero = 1'b0;
    mem_if.mem_ready = 1'b0;
    #1;
    c = '0; c.mem_req = 1; c.alusrcb = 2'b01;
    check("reset ctl", 64'(dut_c), 64'(c));
    check("reset instret", 64'(instret), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b100111, 1'b0, 0, 0);
    run_instr(6'b000101, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b101011, 6'b000000, 1'b1, 0, 3);
    run_instr(6'b111111, 6'b000000, 1'b0, 1, 0);
    run_instr(6'b000000, 6'b111111, 1'b1, 0, 0);
    run_instr(6'b000010, 6'b000000, 1'b1, 2, 0);

    for (int n = 0; n < 200; n++) run_random();

    // Reset asserted while a load waits on memory.
    @(negedge clk);
    opcode = 6'b100011;
    mem_if.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_if.mem_ready = 1'b0;
    #1;
    c = '0; c.mem_req = 1; c.iord = 1;
    check("memrd before reset", 64'(dut_c), 64'(c));
    rst_n = 1'b0;
    #1;
    c = '0; c.mem_req = 1; c.alusrcb = 2'b01;
    check("async reset ctl", 64'(dut_c), 64'(c));
    check("async reset instret", 64'(instret), 64'd0);
    cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(6'b100011, 6'b000000, 1'b0, 0, 1);
    run_instr(6'b001010, 6'b000000, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    check("final instret", 64'(instret), 64'(cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control unit for the MIPS datapath and the clocked successor of the single-cycle decoder. One FSM sequences fetch, decode, execute, memory and writeback over 3–5+ cycles per instruction, with a valid/ready stall handshake on the shared instruction/data memory. It adds `bne`, a parametrised ALU-control width, a retired-instruction counter, and an optional illegal-instruction trap. It drives all datapath mux selects, write enables and the PC enable.

## Interface
- `ACTRL_W`, 3: ALU control width, ≥3; upper bits are driven 0.
- `CNT_W`, 32: retired-instruction counter width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `opcode` in 6: instruction register [31:26].
- `funct` in 6: instruction register [5:0].
- `zero` in 1: ALU zero flag for the current cycle.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memwrite` out 1: memory write.
- `irwrite` out 1: instruction register load.
- `regdst` out 1: register destination, 1 = rd, 0 = rt.
- `memtoreg` out 1: writeback source, 1 = MDR.
- `regwrite` out 1: register file write.
- `alusrca` out 1: ALU A source, 0 = PC, 1 = rs.
- `alusrcb` out 2: ALU B source, 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- `aluctrl` out `ACTRL_W`: ALU operation code.
- `pcsrc` out 2: next PC source, 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = exception vector.
- `pcen` out 1: PC load.
- `illegal` out 1: one-cycle trap pulse.
- `instret` out `CNT_W`: count of retired instructions.

## Operation
- Moore FSM; outputs decode from the state register. The only exceptions are `irwrite`/`pcen` gating by `mem_ready` in FETCH and `pcen` depending on `zero` in BRANCH.
- ALU codes: add 000, sub 001, and 010, or 011, slt 101, nor 110.
- FETCH: `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluctrl`=add, `pcsrc`=00. `irwrite`=`pcen`=`mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `alusrcb`=11, `aluctrl`=add (computes the branch target). Dispatch by opcode:
  - `lw` (100011) or `sw` (101011) → MEMADR.
  - R-type (000000) with a legal funct → RTYPE.
  - `addi`/`andi`/`ori`/`slti` (001000/001100/001101/001010) → IMMEX.
  - `beq` (000100) or `bne` (000101) → BRANCH.
  - `j` (000010) → JUMP.
  - Anything else → illegal handling (see Configuration).
- Legal R-type funct values: add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010.
- MEMADR: `alusrca`=1, `alusrcb`=10, add. Goes to MEMRD (`lw`) or MEMWR (`sw`).
- MEMRD: `mem_req`=1, `iord`=1. Holds until `mem_ready`, then MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0. Retires the instruction.
- MEMWR: `mem_req`=1, `iord`=1, `memwrite`=1. Holds until `mem_ready`, then retires.
- RTYPE: `alusrca`=1, `alusrcb`=00, `aluctrl` from funct. Goes to ALUWB.
- ALUWB: `regwrite`=1, `regdst`=1. Retires.
- IMMEX: `alusrca`=1, `alusrcb`=10, `aluctrl` = add/and/or/slt per opcode. Goes to IMMWB.
- IMMWB: `regwrite`=1, `regdst`=0. Retires.
- BRANCH: `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01. `pcen` = `zero` for `beq`, `!zero` for `bne`. Retires.
- JUMP: `pcsrc`=10, `pcen`=1. Retires.
- Every output not listed for a state is 0 in that state.
- Retiring an instruction increments `instret` on the state's exit edge and returns the FSM to FETCH. `instret` wraps to 0 modulo 2^`CNT_W`.

## Timing
- Reset: state = FETCH and `instret` = 0 asynchronously. Outputs therefore show FETCH decode: `mem_req`=1, `alusrcb`=01, all others 0 except `irwrite`/`pcen` = `mem_ready`.
- Reset asserted mid-instruction abandons it; no retire is counted.
- Zero-wait-state latency: `lw` 5 cycles; `sw`, R-type and immediate ops 4; `beq`/`bne`/`j` 3. Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_req`, `iord` and `memwrite` are held stable while waiting. The access completes in the cycle where `mem_req` and `mem_ready` are both 1.
- `mem_ready` outside the memory states is ignored.

## Configuration
- `MC_TRAP_EN` defined: an illegal opcode or R-type funct goes DECODE → TRAP. TRAP lasts one cycle with `illegal`=1, `pcsrc`=11, `pcen`=1, then FETCH. It is not counted in `instret`.
- `MC_TRAP_EN` undefined: an illegal instruction goes DECODE → FETCH as a 2-cycle NOP. It is not counted. `illegal` is tied to 0 and `pcsrc` never takes 11.

## Structure
- Package `mips_ctrl_pkg`: the state enum, opcode and funct localparams, and the ALU code localparams.
- Sub-module `mips_alu_decoder`: combinational funct/opcode → `aluctrl` and legal flag. It is instantiated once; the FSM stays in the top.

## Test plan
- `mem_ready`=1, `lw` (100011): states FETCH, DECODE, MEMADR, MEMRD, MEMWB; `regwrite`=1 and `memtoreg`=1 in cycle 5; `instret` 0→1.
- R-type `nor` (funct 100111): `aluctrl`=110 in RTYPE; `regdst`=1 and `regwrite`=1 in the next cycle; 4 cycles total.
- `bne` with `zero`=0, then `beq` with `zero`=0: `pcen`=1, `pcsrc`=01 for the first; `pcen`=0 for the second; both count as retired.
- `sw` with `mem_ready` low for 3 cycles in MEMWR: `memwrite`/`mem_req`/`iord` held for 4 cycles; 7 cycles total.
- Opcode 111111 with `MC_TRAP_EN`: one `illegal` pulse, `pcsrc`=11, `instret` unchanged. Without the macro: back in FETCH after 2 cycles, `illegal`=0.
- `rst_n` low during MEMRD: asynchronous return to FETCH, `instret`=0; with `CNT_W`=4, 16 retires wrap the counter to 0.
